sevenseg_capture: RTL



---
 rtl/sevenseg_pkg.sv | 45 ++++
 rtl/sevenseg_decode.sv | 39 +++
 rtl/sevenseg_capture.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment capture path: segment bit order,
// the 16 active-low hex glyphs, the blank pattern and the capture FSM states.
package sevenseg_pkg;

    localparam int SEG_W = 7;

    // seg_L bit order is {g,f,e,d,c,b,a}; all segment lines are active-low
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [SEG_W-1:0] SEG_BLANK  = 7'h7F;

    localparam logic [SEG_W-1:0] SEG_CODE_0 = 7'h40;
    localparam logic [SEG_W-1:0] SEG_CODE_1 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_CODE_2 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_CODE_3 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_CODE_4 = 7'h19;
    localparam logic [SEG_W-1:0] SEG_CODE_5 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_CODE_6 = 7'h02;
    localparam logic [SEG_W-1:0] SEG_CODE_7 = 7'h78;
    localparam logic [SEG_W-1:0] SEG_CODE_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_CODE_9 = 7'h10;
    localparam logic [SEG_W-1:0] SEG_CODE_A = 7'h08;
    localparam logic [SEG_W-1:0] SEG_CODE_B = 7'h03;
    localparam logic [SEG_W-1:0] SEG_CODE_C = 7'h46;
    localparam logic [SEG_W-1:0] SEG_CODE_D = 7'h21;
    localparam logic [SEG_W-1:0] SEG_CODE_E = 7'h06;
    localparam logic [SEG_W-1:0] SEG_CODE_F = 7'h0E;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_HELD   = 1'b1
    } cap_state_e;

    typedef struct packed {
        logic [3:0] value;
        logic       legal;
    } seg_dec_t;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational inverse of the hex glyph table: active-low segment pattern
// to 4-bit value, with legal cleared for any pattern outside the table.
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [SEG_W-1:0] seg_L,
    output logic [3:0]       value,
    output logic             legal
);

    seg_dec_t dec;

    always_comb begin
        dec = '{value: 4'h0, legal: 1'b1};
        case (seg_L)
            SEG_CODE_0: dec.value = 4'h0;
            SEG_CODE_1: dec.value = 4'h1;
            SEG_CODE_2: dec.value = 4'h2;
            SEG_CODE_3: dec.value = 4'h3;
            SEG_CODE_4: dec.value = 4'h4;
            SEG_CODE_5: dec.value = 4'h5;
            SEG_CODE_6: dec.value = 4'h6;
            SEG_CODE_7: dec.value = 4'h7;
            SEG_CODE_8: dec.value = 4'h8;
            SEG_CODE_9: dec.value = 4'h9;
            SEG_CODE_A: dec.value = 4'hA;
            SEG_CODE_B: dec.value = 4'hB;
            SEG_CODE_C: dec.value = 4'hC;
            SEG_CODE_D: dec.value = 4'hD;
            SEG_CODE_E: dec.value = 4'hE;
            SEG_CODE_F: dec.value = 4'hF;
            default:    dec.legal = 1'b0;
        endcase
    end

    assign value = dec.value;
    assign legal = dec.legal;

endmodule

// File: rtl/sevenseg_capture.sv
// Display monitor: waits for each multiplexed digit slot to be stable for
// STABLE_CYCLES samples, decodes it and holds one value per digit.
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NDIG-1:0]   an_L,
    input  logic [SEG_W-1:0]  seg_L,
    input  logic              clr,
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   digit_ok,
    output logic              frame_valid,
    output logic              bad_seg,
    output logic              bad_an
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam int              SMP_W    = NDIG + SEG_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES);

    cap_state_e             state_q, state_d;
    logic [SMP_W-1:0]       p_q, p_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic [SMP_W-1:0]       smp_in;
    logic                   commit;

    logic [NDIG-1:0][3:0]   digits_q, digits_d;
    logic [NDIG-1:0]        ok_q, ok_d;
    logic [NDIG-1:0]        seen_q, seen_d;
    logic                   frame_q, frame_d;
    logic                   bad_seg_q, bad_seg_d;
    logic                   bad_an_q, bad_an_d;

    logic [NDIG-1:0]        an_low;
    logic                   an_blank;
    logic                   an_multi;
    logic [3:0]             dec_value;
    logic                   dec_legal;

    assign smp_in  = {an_L, seg_L};
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Stability tracker: cnt only advances in SETTLE, so it saturates at
    // STABLE_CYCLES once the slot is held.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                if (smp_in != p_q) begin
                    p_d   = smp_in;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        commit  = 1'b1;
                        state_d = ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                if (smp_in != p_q) begin
                    p_d     = smp_in;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
        endcase
    end

    // The committed sample equals p_q on the commit edge, so decode from the
    // register rather than the raw bus.
    assign an_low   = ~p_q[SMP_W-1 -: NDIG];
    assign an_blank = (an_low == '0);
    assign an_multi = ((an_low & (an_low - NDIG'(1))) != '0);

    sevenseg_decode u_decode (
        .seg_L (p_q[SEG_W-1:0]),
        .value (dec_value),
        .legal (dec_legal)
    );

    always_comb begin
        digits_d  = digits_q;
        ok_d      = ok_q;
        seen_d    = seen_q;
        bad_seg_d = bad_seg_q;
        bad_an_d  = bad_an_q;
        frame_d   = 1'b0;

        if (commit && !an_blank) begin
            if (an_multi) begin
                bad_an_d = 1'b1;
            end else begin
                seen_d = seen_q | an_low;
                ok_d   = (ok_q & ~an_low) | ({NDIG{dec_legal}} & an_low);
                if (!dec_legal)
                    bad_seg_d = 1'b1;
                for (int k = 0; k < NDIG; k++)
                    if (an_low[k] && dec_legal)
                        digits_d[k] = dec_value;
            end
        end

        // clr overrides the frame bookkeeping but not the digit registers
        if (clr) begin
            seen_d    = '0;
            bad_seg_d = 1'b0;
            bad_an_d  = 1'b0;
        end else if (&seen_d) begin
            frame_d = 1'b1;
            seen_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_SETTLE;
            p_q       <= '1;
            cnt_q     <= '0;
            digits_q  <= '0;
            ok_q      <= '0;
            seen_q    <= '0;
            frame_q   <= 1'b0;
            bad_seg_q <= 1'b0;
            bad_an_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            ok_q      <= ok_d;
            seen_q    <= seen_d;
            frame_q   <= frame_d;
            bad_seg_q <= bad_seg_d;
            bad_an_q  <= bad_an_d;
        end
    end

    assign digits      = digits_q;
    assign digit_ok    = ok_q;
    assign frame_valid = frame_q;
    assign bad_seg     = bad_seg_q;
    assign bad_an      = bad_an_q;

endmodule
